// File: rtl/branch_pc_sequencer.sv
// Multi-cycle next-PC sequencer sharing one external adder for PC+INC and branch target.
// Optional BRANCH_ALIGN_CHECK_EN: reject misaligned taken targets and raise o_misalign.
module branch_pc_sequencer #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] INC      = WIDTH'(4)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req,
    input  logic             i_branch,
    input  logic [WIDTH-1:0] i_offset,
    output logic [WIDTH-1:0] o_add_op1,
    output logic [WIDTH-1:0] o_add_op2,
    input  logic [WIDTH-1:0] i_add_sum,
    output logic [WIDTH-1:0] o_pc,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_misalign
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INC  = 2'd1,
        S_BR   = 2'd2,
        S_UPD  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] seq_q, seq_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-3:0] off_q, off_d;
    logic             br_q, br_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef BRANCH_ALIGN_CHECK_EN
    logic             mis_q, mis_d;
`endif

    // Only the low bits of the offset survive the <<2.
    logic unused_off_hi;
    assign unused_off_hi = ^i_offset[WIDTH-1:WIDTH-2];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        seq_d     = seq_q;
        tgt_d     = tgt_q;
        off_d     = off_q;
        br_d      = br_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef BRANCH_ALIGN_CHECK_EN
        mis_d     = mis_q;
`endif
        o_add_op1 = pc_q;
        o_add_op2 = '0;
        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    br_d    = i_branch;
                    off_d   = i_offset[WIDTH-3:0];
                    busy_d  = 1'b1;
                    state_d = S_INC;
                end
            end
            S_INC: begin
                o_add_op2 = INC;
                seq_d     = i_add_sum;
                state_d   = br_q ? S_BR : S_UPD;
            end
            S_BR: begin
                o_add_op1 = seq_q;
                o_add_op2 = {off_q, 2'b00};
                tgt_d     = i_add_sum;
                state_d   = S_UPD;
            end
            S_UPD: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (!br_q) begin
                    pc_d = seq_q;
                end else begin
`ifdef BRANCH_ALIGN_CHECK_EN
                    if (tgt_q[1:0] != 2'b00) begin
                        mis_d = 1'b1;
                    end else begin
                        pc_d = tgt_q;
                    end
`else
                    pc_d = tgt_q;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            seq_q   <= '0;
            tgt_q   <= '0;
            off_q   <= '0;
            br_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            seq_q   <= seq_d;
            tgt_q   <= tgt_d;
            off_q   <= off_d;
            br_q    <= br_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef BRANCH_ALIGN_CHECK_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end
    assign o_misalign = mis_q;
`else
    assign o_misalign = 1'b0;
`endif

    assign o_pc   = pc_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule
